axi_lite_mem_slave: RTL and testbench
=====================================

# axi_lite_mem_slave

AXI4-Lite responder backed by a byte-addressable word memory. It terminates the master port of the bus block (`m1_axi_*`), serving as the far-end target for bus writes and reads. Write and read channels run independent state machines. Out-of-range accesses return SLVERR.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8
- ADDR_WIDTH, 8, byte address width
- DEPTH, 48, number of DATA_WIDTH words implemented; must be ≤ 2**(ADDR_WIDTH-log2(DATA_WIDTH/8))
- s0_axi_aclk  in  1  single clock; all logic on rising edge
- s0_axi_aresetn  in  1  asynchronous, active-low reset
- s0_axi_awaddr  in  ADDR_WIDTH  write byte address
- s0_axi_awvalid / s0_axi_awready  in / out  1  AW handshake
- s0_axi_wdata  in  DATA_WIDTH  write data
- s0_axi_wstrb  in  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
- s0_axi_wvalid / s0_axi_wready  in / out  1  W handshake
- s0_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s0_axi_bvalid / s0_axi_bready  out / in  1  B handshake
- s0_axi_araddr  in  ADDR_WIDTH  read byte address
- s0_axi_arvalid / s0_axi_arready  in / out  1  AR handshake
- s0_axi_rdata  out  DATA_WIDTH  read data
- s0_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s0_axi_rvalid / s0_axi_rready  out / in  1  R handshake

## Operation
- Word index = addr >> log2(DATA_WIDTH/8); low address bits ignored (no unaligned support). Index ≥ DEPTH is out of range.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AW and W are accepted independently, in either order or the same cycle. Each accepted channel latches its payload and drops its ready.
  - Once both are latched, on the edge the second handshake completes:
    - in range: memory bytes with wstrb=1 are updated; bresp=OKAY
    - out of range: memory untouched; bresp=SLVERR
    - bvalid is set and the FSM moves to W_RESP.
  - wstrb=0 in range gives OKAY with no change.
  - W_RESP: bvalid and bresp are held until bready. On the B handshake edge: bvalid=0, awready=1, wready=1, return to W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On the AR handshake edge: arready=0; rdata=mem[index] (0 if out of range); rresp=OKAY or SLVERR; rvalid=1; go to R_DATA.
  - R_DATA: rdata, rresp and rvalid are held until rready. On the R handshake edge: rvalid=0, arready=1, return to R_IDLE.
- Same-edge write commit and AR handshake to the same word: the read returns the pre-write data.
- Memory contents are not reset.

## Timing
- Reset values: awready=0, wready=0, arready=0, bvalid=0, bresp=00, rvalid=0, rresp=00, rdata=0. Both FSMs reset to idle.
- awready, wready and arready rise on the first rising edge after aresetn deasserts.
- All outputs are registered; there are no combinational input-to-output paths.
- Write latency: bvalid is high 1 cycle after the later of the AW/W handshakes. Minimum 2 cycles per write with bready held high.
- Read latency: rvalid is high 1 cycle after the AR handshake. Minimum 2 cycles per read with rready held high.
- Valid held with ready low: no state change and no payload capture.
- Reset asserted mid-transaction: the transaction is abandoned and outputs go to reset values immediately. A write whose commit edge has not occurred leaves memory unchanged.

## Structure
- Package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - typedef enum {W_IDLE, W_RESP} wr_state_t
  - typedef enum {R_IDLE, R_DATA} rd_state_t
- Sub-module axi_lite_mem_array:
  - DEPTH×DATA_WIDTH byte-enabled storage
  - one synchronous write port with byte enables
  - one synchronous read port with registered output; old data on same-address collision
- Top level holds both FSMs, the address decode and range check, and the handshake registers.

## Test plan
- Reset release: all outputs 0 during reset; one edge after release, awready=wready=arready=1.
- Full write then read: AW 0x10 + W 0xDEADBEEF strb 4'hF in the same cycle -> bvalid next cycle, bresp=00. Then AR 0x10 -> rvalid next cycle, rdata=0xDEADBEEF, rresp=00.
- Partial write and channel ordering:
  - W first (0x11223344, strb 4'b0101), AW 0x10 three cycles later -> bvalid 1 cycle after AW.
  - Readback of 0x10 = 0xDE22BE44.
- Out of range: write 0xC0 -> bresp=10. Read 0xC0 -> rresp=10, rdata=0. Word 0 unchanged.
- Backpressure: bready and rready held low for 5 cycles -> bvalid/rvalid and payload stable; readies stay low; no second transaction accepted.
- Collision and reset:
  - Write commit to 0x20 on the same edge as AR 0x20 -> rdata = old value; a second read returns the new value.
  - aresetn pulsed while bvalid=1 -> bvalid=0 immediately; readies return 1 edge after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and response codes for the AXI4-Lite memory responder.
// Contents: response encodings, write/read FSM state enums.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
// Modports: master drives addresses/data/valids and B/R readies;
//           slave drives AW/W/AR readies and the B/R responses.
interface axi_lite_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_mem_array.sv
// Byte-enabled word storage: one synchronous write port, one synchronous
// read port with a registered output (old data on same-address collision).
// Ports: clk, rst_n (clears only the read register), wr_en/wr_idx/wr_data/
//        wr_strb, rd_en/rd_zero/rd_idx, rd_data.
module axi_lite_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 48,
  parameter int unsigned IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic                    rd_zero,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // rd_zero loads zero for out-of-range reads instead of touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_idx];
  end
endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a DEPTH x DATA_WIDTH byte-enabled memory.
// Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) FSMs;
// out-of-range word indices answer SLVERR. All bus outputs are registered.
// Ports: s0_axi_aclk, s0_axi_aresetn (async, active low), s0_axi (slave modport).
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 48
) (
  input  logic                 s0_axi_aclk,
  input  logic                 s0_axi_aresetn,
  axi_lite_mem_slave_if.slave  s0_axi
);
  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned OFFS       = $clog2(STRB_W);
  localparam int unsigned IDX_FULL_W = ADDR_WIDTH - OFFS;
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic idx_ok(input logic [IDX_FULL_W-1:0] idx);
    return 32'(idx) < DEPTH;
  endfunction

  // Write channel state
  wr_state_t               w_state_q, w_state_d;
  logic                    awready_q, awready_d, wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [IDX_FULL_W-1:0]   aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    mem_wr_c;

  // Read channel state
  rd_state_t               r_state_q, r_state_d;
  logic                    arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    rd_en_c, rd_zero_c;
  logic [IDX_FULL_W-1:0]   ar_idx_c;
  logic [DATA_WIDTH-1:0]   rdata_q;

  // Write FSM: collect AW and W in any order, commit on the later handshake.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mem_wr_c  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s0_axi.awvalid && awready_q) begin
          aw_done_d = 1'b1;
          aw_idx_d  = IDX_FULL_W'(s0_axi.awaddr >> OFFS);
        end
        if (s0_axi.wvalid && wready_q) begin
          w_done_d = 1'b1;
          wdata_d  = s0_axi.wdata;
          wstrb_d  = s0_axi.wstrb;
        end
        // Readies also rise here on the first edge after reset.
        awready_d = !aw_done_d;
        wready_d  = !w_done_d;
        if (aw_done_d && w_done_d) begin
          mem_wr_c  = idx_ok(aw_idx_d);
          bresp_d   = idx_ok(aw_idx_d) ? RESP_OKAY : RESP_SLVERR;
          bvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s0_axi.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Read FSM: one outstanding read, data comes from the array's read register.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rd_en_c   = 1'b0;
    rd_zero_c = 1'b0;
    ar_idx_c  = IDX_FULL_W'(s0_axi.araddr >> OFFS);
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s0_axi.arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = idx_ok(ar_idx_c) ? RESP_OKAY : RESP_SLVERR;
          rd_en_c   = 1'b1;
          rd_zero_c = !idx_ok(ar_idx_c);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s0_axi.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_lite_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (s0_axi_aclk),
    .rst_n   (s0_axi_aresetn),
    .wr_en   (mem_wr_c),
    .wr_idx  (IDX_W'(aw_idx_d)),
    .wr_data (wdata_d),
    .wr_strb (wstrb_d),
    .rd_en   (rd_en_c),
    .rd_zero (rd_zero_c),
    .rd_idx  (IDX_W'(ar_idx_c)),
    .rd_data (rdata_q)
  );

  assign s0_axi.awready = awready_q;
  assign s0_axi.wready  = wready_q;
  assign s0_axi.bvalid  = bvalid_q;
  assign s0_axi.bresp   = bresp_q;
  assign s0_axi.arready = arready_q;
  assign s0_axi.rvalid  = rvalid_q;
  assign s0_axi.rresp   = rresp_q;
  assign s0_axi.rdata   = rdata_q;
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: directed vector table,
// hand-written corner sequences and random traffic against an array model.
module tb_axi_lite_mem_slave;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem_m [DEPTH];

  axi_lite_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .s0_axi_aclk    (clk),
    .s0_axi_aresetn (rst_n),
    .s0_axi         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_bresp;
    logic [7:0]  rd_addr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference model: word index = addr/4, valid below DEPTH.
  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx = int'(addr) / 4;
    if (idx >= int'(DEPTH)) return 2'b10;
    for (int b = 0; b < 4; b++) if (strb[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [7:0] addr);
    int idx = int'(addr) / 4;
    if (idx >= int'(DEPTH)) return {2'b10, 32'h0};
    return {2'b00, mem_m[idx]};
  endfunction

  task automatic send_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
    bit aw_ok = 0, w_ok = 0, aw_hit, w_hit;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    for (int cyc = 0; cyc < 60 && !(aw_ok && w_ok); cyc++) begin
      @(negedge clk);
      if (!aw_ok && cyc >= aw_dly) bus.awvalid = 1'b1;
      if (!w_ok && cyc >= w_dly) bus.wvalid = 1'b1;
      aw_hit = bus.awvalid && bus.awready;
      w_hit  = bus.wvalid && bus.wready;
      @(posedge clk);
      #1;
      if (aw_hit) begin aw_ok = 1; bus.awvalid = 1'b0; end
      if (w_hit)  begin w_ok = 1;  bus.wvalid = 1'b0;  end
      if (!(aw_ok && w_ok)) check("b_early", 32'(bus.bvalid), 32'd0);
    end
    if (!(aw_ok && w_ok)) begin
      timeout_fail("write_handshake");
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
    end else begin
      check("b_latency", 32'(bus.bvalid), 32'd1);
    end
  endtask

  task automatic take_b(input int dly, output logic [1:0] resp);
    int n = 0;
    resp = 2'bxx;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) begin timeout_fail("bvalid_wait"); return; end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk);
    #1;
    bus.bready = 1'b0;
    check("b_release", 32'(bus.bvalid), 32'd0);
    check("aw_ready_back", 32'(bus.awready & bus.wready), 32'd1);
  endtask

  task automatic send_read(input logic [7:0] addr, input int dly);
    bit ok = 0, hit;
    bus.araddr = addr;
    for (int cyc = 0; cyc < 60 && !ok; cyc++) begin
      @(negedge clk);
      if (cyc >= dly) bus.arvalid = 1'b1;
      hit = bus.arvalid && bus.arready;
      @(posedge clk);
      #1;
      if (hit) begin ok = 1; bus.arvalid = 1'b0; end
    end
    if (!ok) begin
      timeout_fail("read_handshake");
      bus.arvalid = 1'b0;
    end else begin
      check("r_latency", 32'(bus.rvalid), 32'd1);
    end
  endtask

  task automatic take_r(input int dly, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    data = 'x;
    resp = 2'bxx;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.rvalid) begin timeout_fail("rvalid_wait"); return; end
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
    check("r_release", 32'(bus.rvalid), 32'd0);
    check("ar_ready_back", 32'(bus.arready), 32'd1);
  endtask

  task automatic read_vs_model(input string name, input logic [7:0] addr, input int dly);
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] m;
    m = model_read(addr);
    send_read(addr, dly);
    take_r(dly, d, r);
    check({name, "_rdata"}, d, m[31:0]);
    check({name, "_rresp"}, 32'(r), 32'(m[33:32]));
  endtask

  initial begin
    vec_t        vecs[8];
    logic [1:0]  resp;
    logic [1:0]  exp_r;
    logic [31:0] data;
    logic [31:0] old_v;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    vecs[0] = '{8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 8'h10, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{8'h10, 32'h11223344, 4'h5, 3, 0, 2'b00, 8'h10, 32'hDE22BE44, 2'b00};
    vecs[2] = '{8'hC0, 32'h12345678, 4'hF, 0, 2, 2'b10, 8'hC0, 32'h00000000, 2'b10};
    vecs[3] = '{8'h14, 32'hFFFFFFFF, 4'h0, 1, 1, 2'b00, 8'h14, 32'hA5000005, 2'b00};
    vecs[4] = '{8'hFC, 32'hCAFEF00D, 4'hF, 0, 0, 2'b10, 8'hBC, 32'hA500002F, 2'b00};
    vecs[5] = '{8'hBD, 32'h0000AB00, 4'h2, 2, 0, 2'b00, 8'hBF, 32'hA500AB2F, 2'b00};
    vecs[6] = '{8'hC4, 32'h77777777, 4'hF, 1, 0, 2'b10, 8'h00, 32'hA5000000, 2'b00};
    vecs[7] = '{8'h02, 32'h99887766, 4'h8, 0, 1, 2'b00, 8'h00, 32'h99000000, 2'b00};

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values and ready rise after release.
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready",  32'(bus.wready), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_bvalid",  32'(bus.bvalid), 0);
    check("rst_bresp",   32'(bus.bresp), 0);
    check("rst_rvalid",  32'(bus.rvalid), 0);
    check("rst_rresp",   32'(bus.rresp), 0);
    check("rst_rdata",   bus.rdata, 0);
    rst_n = 1'b1;
    #1;
    check("rel_awready_pre", 32'(bus.awready), 0);
    @(posedge clk);
    #1;
    check("rel_awready", 32'(bus.awready), 1);
    check("rel_wready",  32'(bus.wready), 1);
    check("rel_arready", 32'(bus.arready), 1);

    // Give every word a known value.
    for (int i = 0; i < int'(DEPTH); i++) begin
      send_write(8'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, 0, 0);
      take_b(0, resp);
      exp_r = model_write(8'(i * 4), 32'hA500_0000 | 32'(i), 4'hF);
      check("init_bresp", 32'(resp), 32'(exp_r));
    end

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      send_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].aw_dly, vecs[v].w_dly);
      take_b(v % 2, resp);
      check($sformatf("vec%0d_bresp", v), 32'(resp), 32'(vecs[v].exp_bresp));
      void'(model_write(vecs[v].addr, vecs[v].data, vecs[v].strb));
      send_read(vecs[v].rd_addr, v % 3);
      take_r(v % 2, data, resp);
      check($sformatf("vec%0d_rdata", v), data, vecs[v].exp_rdata);
      check($sformatf("vec%0d_rresp", v), 32'(resp), 32'(vecs[v].exp_rresp));
    end

    // Backpressure on B.
    send_write(8'h18, 32'h5A5A5A5A, 4'hF, 0, 0);
    void'(model_write(8'h18, 32'h5A5A5A5A, 4'hF));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_bvalid", 32'(bus.bvalid), 1);
      check("bp_bresp", 32'(bus.bresp), 0);
      check("bp_wr_readies", 32'({bus.awready, bus.wready}), 0);
    end
    take_b(0, resp);
    check("bp_bresp_final", 32'(resp), 0);

    // Backpressure on R.
    send_read(8'h18, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rvalid", 32'(bus.rvalid), 1);
      check("bp_rdata", bus.rdata, 32'h5A5A5A5A);
      check("bp_arready", 32'(bus.arready), 0);
    end
    take_r(0, data, resp);
    check("bp_rdata_final", data, 32'h5A5A5A5A);

    // Write commit and AR to the same word on the same edge.
    old_v = mem_m[8];
    @(negedge clk);
    bus.awaddr = 8'h20; bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.araddr = 8'h20;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    check("col_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'd7);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("col_bvalid", 32'(bus.bvalid), 1);
    check("col_rvalid", 32'(bus.rvalid), 1);
    take_r(0, data, resp);
    check("col_old_data", data, old_v);
    take_b(0, resp);
    check("col_bresp", 32'(resp), 0);
    void'(model_write(8'h20, 32'h0BADF00D, 4'hF));
    read_vs_model("col_new", 8'h20, 0);

    // Reset while bvalid is pending.
    send_write(8'h24, 32'h600DCAFE, 4'hF, 0, 0);
    void'(model_write(8'h24, 32'h600DCAFE, 4'hF));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(bus.bvalid), 0);
    check("mid_rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 0);
    check("mid_rst_rdata", bus.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_pre", 32'(bus.awready), 0);
    @(posedge clk);
    #1;
    check("mid_rel_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'd7);

    // Reset after only AW is accepted: the latched address must be dropped.
    @(negedge clk);
    bus.awaddr = 8'h28; bus.awvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    check("aw_only_taken", 32'({bus.awready, bus.wready}), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_write(8'h2C, 32'h13572468, 4'hF, 1, 0);
    take_b(0, resp);
    check("post_rst_bresp", 32'(resp), 0);
    void'(model_write(8'h2C, 32'h13572468, 4'hF));
    read_vs_model("post_rst_28", 8'h28, 0);
    read_vs_model("post_rst_2c", 8'h2C, 0);
    read_vs_model("post_rst_24", 8'h24, 1);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
      else                           a = 8'($urandom_range(0, 191));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        send_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        take_b(int'($urandom_range(0, 2)), resp);
        exp_r = model_write(a, d, s);
        check("rand_bresp", 32'(resp), 32'(exp_r));
      end else begin
        read_vs_model("rand", a, int'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
